// File: rtl/dbg_regfile_access.sv
// dbg_regfile_access
// Debug-side initiator for the integer register file. It accepts one
// abstract register read or write command at a time from the debug module.
// It drives the register file write port (rf_we/rf_a3/rf_wd3) and read
// port (rf_a1/rf_rd1) for a single ACCESS cycle, then holds one response
// on a valid/ready channel until the debug module consumes it.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   halted                  core halted; sampled only when a command is accepted
//   req_valid/req_ready     command handshake
//   req_write/req_regno/req_wdata   command payload
//   rsp_valid/rsp_ready     response handshake
//   rsp_data/rsp_err        response payload (data is 0 for writes and errors)
//   busy                    high from accept until the response handshake
//   rf_we/rf_a3/rf_wd3      register file write port drive
//   rf_a1/rf_rd1            register file read port (rf_rd1 combinational from rf_a1)
module dbg_regfile_access #(
  parameter int XLEN        = 64,
  parameter bit E_SUPPORTED = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            halted,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [4:0]      req_regno,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic            busy,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd3,
  output logic [4:0]      rf_a1,
  input  logic [XLEN-1:0] rf_rd1
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [4:0]        regno_q, regno_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  // Keeps req_ready low while reset is asserted and for the first edge
  // after release, so no command can be accepted out of a reset state.
  logic              ready_q;

  logic              regno_illegal;

  // Registers x16..x31 do not exist on an E-variant core.
  assign regno_illegal = E_SUPPORTED && req_regno[4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      regno_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      regno_q <= regno_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    regno_d   = regno_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    busy      = 1'b0;
    rf_we     = 1'b0;
    rf_a3     = '0;
    rf_wd3    = '0;
    rf_a1     = '0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = ready_q;
        if (req_valid && ready_q) begin
          write_d = req_write;
          regno_d = req_regno;
          wdata_d = req_wdata;
          rdata_d = '0;
          if (!halted || regno_illegal) begin
            // Rejected commands skip the register file entirely.
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        busy   = 1'b1;
        rf_a1  = regno_q;
        rf_a3  = regno_q;
        rf_wd3 = wdata_q;
        // x0 is hardwired: writes are dropped and reads return zero
        // regardless of what the register file presents.
        rf_we  = write_q && (regno_q != 5'd0);
        if (!write_q && (regno_q != 5'd0)) begin
          rdata_d = rf_rd1;
        end else begin
          rdata_d = '0;
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = rdata_q;
        rsp_err   = err_q;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/dbg_regfile_access.md
Name: dbg_regfile_access

Overview:
- Debug-side initiator for the integer register file: accepts abstract register read/write commands from the debug module and drives the register file's write port and one read port while the core is halted.
- Returns one response per command over a valid/ready channel.
- Sits between the debug module and the IEU; its register-file drive outputs are muxed onto the regfile ports by the IEU when `busy` is high.

Parameters:
- XLEN, 64, data width of register contents
- E_SUPPORTED, 0, 1 = RV32E/RV64E (16 registers); regno >= 16 is then an error

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- halted  input  1  core is halted; sampled only at command accept
- req_valid  input  1  command valid
- req_ready  output  1  command accepted when req_valid & req_ready
- req_write  input  1  1 = write, 0 = read
- req_regno  input  5  target register number
- req_wdata  input  XLEN  write data
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
- rsp_data  output  XLEN  read data; 0 for writes and errors
- rsp_err  output  1  command rejected, no register access performed
- busy  output  1  high from accept until response handshake; debug module must not resume the core while high
- rf_we  output  1  register file write enable
- rf_a3  output  5  register file write address
- rf_wd3  output  XLEN  register file write data
- rf_a1  output  5  register file read address
- rf_rd1  input  XLEN  register file read data, combinational from rf_a1

Behaviour:
- Reset (async, reset_n low): state IDLE.
  - req_ready=0 during reset; 1 in IDLE after reset.
  - rsp_valid=0, rsp_err=0, rsp_data=0, busy=0, rf_we=0, rf_a3=0, rf_wd3=0, rf_a1=0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1; all other outputs low/zero.
  - On accept, latch write, regno and wdata into internal registers.
  - Error if !halted, or if E_SUPPORTED and regno[4]=1:
    - go to RESP with err=1 and data=0.
  - Otherwise go to ACCESS.
  - busy goes high the cycle after accept and remains high through RESP.
- ACCESS (exactly one cycle):
  - rf_a1 = rf_a3 = latched regno; rf_wd3 = latched wdata.
  - Write:
    - rf_we=1 for exactly this cycle, except when regno=0: rf_we stays 0, the write is silently discarded, err=0.
    - The regfile commits on the falling edge within this cycle.
  - Read:
    - rf_rd1 is captured at the end of this cycle.
    - regno=0 returns 0 without relying on rf_rd1.
  - Next state: RESP.
- RESP:
  - rsp_valid=1; rsp_data/rsp_err are stable until the handshake. Read data is XLEN wide and unmodified.
  - On rsp_ready: next cycle IDLE, rsp_valid=0, busy=0.
  - rsp_ready may already be high on the first RESP cycle.
- Latency:
  - Accept at edge N → rsp_valid at N+2 for a legal access.
  - Accept at edge N → rsp_valid at N+1 for an error.
- Throughput: one outstanding command; req_ready=0 outside IDLE. Back-to-back commands are accepted at best every 3 cycles for legal accesses.
- A write followed by a read of the same register returns the new value; no bypass is needed because the write commits before the read's ACCESS cycle.
- rf_we is never high outside ACCESS.
- halted deasserting after accept does not abort the command; busy exists to prevent this.
- Reset mid-operation: all state is discarded immediately, no response is issued, and rf_we drops asynchronously.

Test Plan:
- halted=1; write x5=0xDEADBEEF_00000001 → rf_we high exactly one cycle with rf_a3=5 and rf_wd3 matching; rsp_valid at N+2 with err=0 and data=0.
- Then read x5 → rf_a1=5 in the ACCESS cycle; rsp_data=0xDEADBEEF_00000001, err=0.
- Write x0=0xFFFF, then read x0 → rf_we never asserted; both responses err=0; read data=0.
- halted=0, read x3 → rsp_valid at N+1 with err=1 and data=0; no rf_we; rf_a1 stays 0.
- E_SUPPORTED=1, write x17 → err=1 with no rf_we. Write x15 → succeeds.
- Hold rsp_ready=0 for 5 cycles → rsp_valid/data stay stable and req_ready=0. Then assert rsp_ready → IDLE next cycle.
- Assert reset_n=0 during ACCESS of a write → rf_we drops immediately; after release rsp_valid=0 and req_ready=1.
